toy_fetch_unit: RTL and testbench
=================================

Name: toy_fetch_unit

Overview:
- Instruction-fetch sequencer for the TOY single-cycle core; the producing side of the opcode/flag control path.
- Owns the PC and fetches 16-bit words from instruction memory over a req/ack handshake.
- Presents the instruction and its opcode field (instr[15:12]) to the decode/control stage with a valid/ready handshake.
- Takes back halt and branch-redirect decisions from the decode/control stage to select the next PC.

Parameters:
- AW, 8, instruction address width (TOY memory has 256 words)
- RESET_PC, 8'h10, PC value loaded on reset
- TIMEOUT, 15, maximum cycles to wait for imem_ack before declaring a fault; must be 1..255

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, level
- imem_addr  out  AW  fetch address; equals pc while imem_req=1
- imem_ack  in  1  memory response valid; imem_rdata is valid in this cycle
- imem_rdata  in  16  fetched instruction word
- instr  out  16  instruction register
- op  out  4  instr[15:12], drives the controller opcode input
- instr_valid  out  1  instr/op hold an unconsumed instruction
- instr_ready  in  1  decode/execute stage accepts the instruction
- halt  in  1  decode says the issued instruction is HALT (op 0000); sampled on accept
- redirect  in  1  branch/jump taken; sampled on accept
- redirect_pc  in  AW  branch target; sampled on accept
- pc  out  AW  address of the current or last-fetched instruction
- halted  out  1  sticky; core stopped by HALT
- fault  out  1  sticky; fetch timeout occurred

Behaviour:
- States: START, FETCH, ISSUE, HALT, FAULT.
- Reset (asynchronous, any state):
  - state=START, pc=RESET_PC, instr=16'h0000, instr_valid=0.
  - imem_req=0, halted=0, fault=0, timeout counter=0.
- START: lasts exactly one cycle with imem_req=0, so a stale ack from before reset cannot be captured. Then goes to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - The transfer completes on the rising edge where imem_req & imem_ack.
  - On completion: instr<=imem_rdata, instr_valid<=1, counter<=0, go to ISSUE.
  - Each cycle without ack increments the counter. When the counter reaches TIMEOUT with no ack: imem_req<=0, fault<=1, go to FAULT.
  - Minimum latency: ack in the first FETCH cycle puts instr_valid high the next cycle.
- ISSUE:
  - instr_valid=1, imem_req=0; instr/op held stable until accepted.
  - Accept happens on the edge where instr_valid & instr_ready. On accept, in priority order:
    - halt=1: go to HALT, halted<=1, pc unchanged.
    - else redirect=1: pc<=redirect_pc, go to FETCH.
    - else: pc<=pc+1, modulo 2^AW (pc=8'hFF wraps to 8'h00), go to FETCH.
  - instr_valid drops to 0 the cycle after accept.
  - halt, redirect and redirect_pc are ignored when there is no accept.
- HALT and FAULT:
  - Terminal; left only by reset. instr_valid=0, imem_req=0.
  - instr and pc keep their last values for debug.
- imem_ack outside FETCH is ignored and causes no state change.
- Throughput: at most one instruction per 2 cycles (FETCH + ISSUE); no prefetch.
- All outputs are registered except op (a slice of instr) and imem_addr (equals pc).

Optional Feature:
- Macro: TOY_ICOUNT_EN.
- Defined:
  - Adds output port icount (16 bits): count of accepted instructions, including the HALT accept.
  - Reset to 0; wraps at 16'hFFFF to 0.
  - Holds its value in HALT and FAULT.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, memory acks every request immediately, instr_ready=1, no redirect -> imem_addr sequence 0x10,0x11,0x12; instr_valid pulses every 2nd cycle; op matches rdata[15:12].
- Issue with redirect=1, redirect_pc=0x40 and halt=0 at accept -> next imem_addr=0x40; with halt=1 and redirect=1 together -> halted=1, no further imem_req, pc stays at the HALT address.
- instr_ready held low for 5 cycles while in ISSUE -> instr/op/instr_valid stable and imem_req=0 throughout; advance occurs on the first ready cycle.
- Ack withheld TIMEOUT=15 cycles -> fault=1, imem_req=0; a later ack is ignored and fault stays set until rst_n.
- Start at pc=0xFF with sequential fetch -> next address 0x00; rst_n asserted mid-FETCH with ack already high -> one START cycle with req=0, fetch restarts at 0x10; with TOY_ICOUNT_EN defined, icount equals the number of accepts.

Source files
------------

// File: rtl/toy_fetch_unit.sv
// -----------------------------------------------------------------------------
// toy_fetch_unit
//
// Instruction-fetch sequencer for the TOY single-cycle core. It owns the PC,
// fetches one 16-bit word at a time from instruction memory over a req/ack
// handshake, and presents it to decode/control over a valid/ready handshake.
// On accept, decode returns halt/redirect decisions that select the next PC.
// There is no prefetch, so throughput is at most one instruction per two
// cycles (FETCH + ISSUE).
//
// Optional build macro:
//   TOY_ICOUNT_EN - adds a 16-bit 'icount' output that counts accepted
//                   instructions, including the accept of a HALT.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request (level), high only in FETCH
//   imem_addr    out  AW  fetch address, always equal to pc
//   imem_ack     in   1   memory response; imem_rdata valid this cycle
//   imem_rdata   in   16  fetched instruction word
//   instr        out  16  instruction register
//   op           out  4   instr[15:12], opcode to the controller
//   instr_valid  out  1   instr/op hold an unconsumed instruction
//   instr_ready  in   1   decode/execute accepts the instruction
//   halt         in   1   issued instruction is HALT (sampled on accept)
//   redirect     in   1   branch/jump taken (sampled on accept)
//   redirect_pc  in   AW  branch target (sampled on accept)
//   pc           out  AW  address of the current or last-fetched instruction
//   halted       out  1   sticky: core stopped by HALT
//   fault        out  1   sticky: fetch timeout occurred
//   icount       out  16  accepted-instruction count (TOY_ICOUNT_EN only)
// -----------------------------------------------------------------------------
module toy_fetch_unit #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = 'h10,
  parameter int            TIMEOUT  = 15    // 1..255
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic [15:0]   instr,
  output logic [3:0]    op,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          halt,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          fault
`ifdef TOY_ICOUNT_EN
  ,
  output logic [15:0]   icount
`endif
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // The counter value that, if still no ack, means TIMEOUT waiting cycles
  // have elapsed in this FETCH.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [15:0]     icount_q, icount_d;

  logic            fetch_done;
  logic            accept;

  // req_q is only ever high in FETCH, so it qualifies ack by itself; acks in
  // any other state are ignored.
  assign fetch_done = req_q & imem_ack;
  assign accept     = valid_q & instr_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_START;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      tmo_q    <= 8'd0;
      icount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      tmo_q    <= tmo_d;
      icount_q <= icount_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. imem_req is registered: req_d is set exactly on the
  // transitions that enter or remain in FETCH.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    req_d    = req_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    tmo_d    = tmo_q;
    icount_d = icount_q;

    case (state_q)
      // One dead cycle with req low so an ack left over from before reset
      // can never be mistaken for a response.
      S_START: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        tmo_d   = 8'd0;
      end

      S_FETCH: begin
        if (fetch_done) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          tmo_d   = 8'd0;
          state_d = S_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          tmo_d   = tmo_q + 8'd1;
          state_d = S_FAULT;
        end else begin
          tmo_d   = tmo_q + 8'd1;
        end
      end

      S_ISSUE: begin
        if (accept) begin
          valid_d  = 1'b0;
          icount_d = icount_q + 16'd1;
          // halt outranks redirect; the PC is frozen at the HALT address.
          if (halt) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = redirect ? redirect_pc : pc_q + AW'(1);
            req_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_HALT, S_FAULT: begin
        // Terminal until reset; instr and pc retained for debug.
        valid_d = 1'b0;
        req_d   = 1'b0;
      end

      default: begin
        // Unreachable encodings park safely with the fault flag raised.
        valid_d = 1'b0;
        req_d   = 1'b0;
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[15:12];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

`ifdef TOY_ICOUNT_EN
  assign icount = icount_q;
`else
  // Counter is optimised away when the port is absent.
  logic unused_icount;
  assign unused_icount = ^icount_q;
`endif

endmodule

// File: tb/tb_toy_fetch_unit.sv
module tb_toy_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [3:0]  op;
  logic        instr_valid;
  logic        instr_ready;
  logic        halt;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic        halted;
  logic        fault;
`ifdef TOY_ICOUNT_EN
  logic [15:0] icount;
`endif

  // Memory side: auto_ack answers any request at once; force_ack holds ack
  // high regardless of request (stale/late acks).
  logic auto_ack;
  logic force_ack;

  int pass_cnt;
  int total_cnt;

  toy_fetch_unit #(.AW(8), .RESET_PC(8'h10), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault)
`ifdef TOY_ICOUNT_EN
    ,
    .icount      (icount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rdata_of(input logic [7:0] a);
    logic [3:0] lo;
    lo = a[3:0];
    return {lo ^ 4'h9, 4'h3, a};
  endfunction

  assign imem_ack   = force_ack | (auto_ack & imem_req);
  assign imem_rdata = rdata_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what the outputs must be, from the behavioural rules.
  // ---------------------------------------------------------------------------
  localparam int M_START = 0, M_FETCH = 1, M_ISSUE = 2, M_STOP = 3;
  int          m_phase;
  int          m_wait;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_halted;
  logic        m_fault;
  logic [15:0] m_icount;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= M_START; m_wait <= 0; m_pc <= 8'h10; m_instr <= 16'h0;
      m_valid <= 1'b0; m_halted <= 1'b0; m_fault <= 1'b0; m_icount <= 16'h0;
    end else begin
      if (m_phase == M_START) begin
        m_phase <= M_FETCH;
        m_wait  <= 0;
      end else if (m_phase == M_FETCH) begin
        if (imem_ack) begin
          m_instr <= rdata_of(m_pc);
          m_valid <= 1'b1;
          m_wait  <= 0;
          m_phase <= M_ISSUE;
        end else if (m_wait + 1 == TIMEOUT) begin
          m_fault <= 1'b1;
          m_phase <= M_STOP;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_phase == M_ISSUE && instr_ready) begin
        m_valid  <= 1'b0;
        m_icount <= m_icount + 16'd1;
        if (halt) begin
          m_halted <= 1'b1;
          m_phase  <= M_STOP;
        end else begin
          m_pc    <= redirect ? redirect_pc : 8'((int'(m_pc) + 1) % 256);
          m_phase <= M_FETCH;
        end
      end
    end
  end

  // Cycle-by-cycle comparison, sampled 2 time units after the active edge.
  always @(posedge clk) begin
    #2;
    check("imem_req",    32'(imem_req),    32'(m_phase == M_FETCH));
    check("imem_addr",   32'(imem_addr),   32'(m_pc));
    check("pc",          32'(pc),          32'(m_pc));
    check("instr",       32'(instr),       32'(m_instr));
    check("op",          32'(op),          32'(m_instr[15:12]));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("halted",      32'(halted),      32'(m_halted));
    check("fault",       32'(fault),       32'(m_fault));
`ifdef TOY_ICOUNT_EN
    check("icount",      32'(icount),      32'(m_icount));
`endif
  end

  // Log of completed fetch addresses.
  logic [7:0] fetch_log[$];
  always @(posedge clk) begin
    if (rst_n && imem_req && imem_ack) fetch_log.push_back(imem_addr);
  end

  task automatic wait_valid();
    for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
    check("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic accept_now(input logic h, input logic r, input logic [7:0] rpc);
    instr_ready = 1'b1; halt = h; redirect = r; redirect_pc = rpc;
    @(negedge clk);
    instr_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
  endtask

  initial begin
    int n;
    int req_cycles;
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; auto_ack = 1'b0; force_ack = 1'b0;
    instr_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc",    32'(pc), 32'h10);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_req",   32'(imem_req), 32'd0);
    $display("reset: pc=%h req=%b valid=%b", pc, imem_req, instr_valid);

    // Sequential streaming, immediate acks, always ready
    auto_ack = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    repeat (8) @(negedge clk);
    instr_ready = 1'b0;
    check("seq_addr0", 32'(fetch_log[0]), 32'h10);
    check("seq_addr1", 32'(fetch_log[1]), 32'h11);
    check("seq_addr2", 32'(fetch_log[2]), 32'h12);
    $display("stream: fetched %h %h %h", fetch_log[0], fetch_log[1], fetch_log[2]);

    // Redirect to 0x40
    wait_valid();
    accept_now(1'b0, 1'b1, 8'h40);
    check("redir_addr", 32'(imem_addr), 32'h40);
    check("redir_req",  32'(imem_req), 32'd1);
    $display("redirect: addr=%h", imem_addr);

    // Stall with ready low for 5 cycles
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req",   32'(imem_req), 32'd0);
    end
    check("stall_instr", 32'(instr), 32'h9340);
    check("stall_op",    32'(op), 32'h9);
    accept_now(1'b0, 1'b0, 8'h00);
    check("stall_next", 32'(imem_addr), 32'h41);
    $display("stall: instr held, next addr=%h", imem_addr);

    // PC wrap from 0xFF to 0x00
    wait_valid();
    accept_now(1'b0, 1'b1, 8'hFF);
    wait_valid();
    check("ff_instr", 32'(instr), 32'h63FF);
    accept_now(1'b0, 1'b0, 8'h00);
    check("wrap_addr", 32'(imem_addr), 32'h00);
    $display("wrap: addr=%h", imem_addr);

    // Halt together with redirect: halt wins
    wait_valid();
    n = fetch_log.size();
    accept_now(1'b1, 1'b1, 8'h55);
    repeat (4) begin
      @(negedge clk);
      check("halt_req", 32'(imem_req), 32'd0);
    end
    check("halted",     32'(halted), 32'd1);
    check("halt_pc",    32'(pc), 32'h00);
    check("halt_nofet", 32'(fetch_log.size()), 32'(n));
    $display("halt: halted=%b pc=%h", halted, pc);

    // Fetch timeout
    rst_n = 1'b0; auto_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_cycles = 0;
    for (int i = 0; i < 100 && !fault; i++) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
    end
    check("tmo_cycles", 32'(req_cycles), 32'(TIMEOUT));
    check("tmo_fault",  32'(fault), 32'd1);
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    force_ack = 1'b0;
    check("tmo_sticky", 32'(fault), 32'd1);
    check("tmo_req",    32'(imem_req), 32'd0);
    $display("timeout: fault=%b after %0d request cycles", fault, req_cycles);

    // Reset in the middle of FETCH with ack already high
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_in_fetch", 32'(imem_req), 32'd1);
    force_ack = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("start_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("restart_req",   32'(imem_req), 32'd1);
    check("restart_addr",  32'(imem_addr), 32'h10);
    check("restart_valid", 32'(instr_valid), 32'd0);
`ifdef TOY_ICOUNT_EN
    check("restart_icount", 32'(icount), 32'd0);
`endif
    @(negedge clk);
    check("restart_instr", 32'(instr), 32'h9310);
    force_ack = 1'b0;
    $display("restart: instr=%h valid=%b", instr, instr_valid);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
